ahblite_obi_arbiter: RTL and testbench

- Shares the single AHB-Lite master port between NUM_REQ OBI-style requesters (req/gnt/rvalid), e.g. core instruction fetch, core data and debug.
- Sequences the AHB-Lite address and data phases, registers write data for the data phase, and routes the response back to the requester that owns that data phase.
- Sits between the core-side ports and the AHB-Lite address decoder/interconnect. It is the only driver of the decoder's `ahbl_*` inputs.

---
 rtl/ahblite_obi_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ahblite_obi_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahblite_obi_arbiter.sv
// Shares one AHB-Lite master port between NUM_REQ OBI-style requesters.
// Latency: grant is combinational in the address cycle. rvalid comes one cycle later, plus one cycle per wait state.
// Backpressure: while hready is low, gnt stays 0 and the address is held (locked to the selected requester).
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   req_i/gnt_o               per-requester request / one-hot grant (address phase accepted)
//   addr_i/we_i/be_i/wdata_i  per-requester request payload, held until gnt
//   rvalid_o/rdata_o/err_o    one-hot response strobe, shared read data, per-requester error
//   ahbl_h*                   AHB-Lite master outputs and hrdata/hready/hresp inputs
module ahblite_obi_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 2
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic [NUM_REQ-1:0]                   req_i,
   output logic [NUM_REQ-1:0]                   gnt_o,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_i,
   input  logic [NUM_REQ-1:0]                   we_i,
   input  logic [NUM_REQ-1:0][3:0]              be_i,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wdata_i,
   output logic [NUM_REQ-1:0]                   rvalid_o,
   output logic [DATA_WIDTH-1:0]                rdata_o,
   output logic [NUM_REQ-1:0]                   err_o,
   output logic [ADDR_WIDTH-1:0]                ahbl_haddr,
   output logic [2:0]                           ahbl_hburst,
   output logic                                 ahbl_hmastlock,
   output logic [3:0]                           ahbl_hprot,
   output logic [2:0]                           ahbl_hsize,
   output logic [1:0]                           ahbl_htrans,
   output logic [DATA_WIDTH-1:0]                ahbl_hwdata,
   output logic                                 ahbl_hwrite,
   input  logic [DATA_WIDTH-1:0]                ahbl_hrdata,
   input  logic                                 ahbl_hready,
   input  logic                                 ahbl_hresp
);

   localparam int         IW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   logic [IW-1:0]         r_last_gnt;
   logic                  r_lock_vld;
   logic [IW-1:0]         r_lock_idx;
   logic                  r_dp_vld;
   logic [IW-1:0]         r_dp_owner;
   logic                  r_dp_we;
   logic [DATA_WIDTH-1:0] r_dp_wdata;

   logic                  w_err_first;
   logic                  w_active;
   logic                  w_rr_hit;
   logic [IW-1:0]         w_rr_idx;
   logic [IW-1:0]         w_k;
   logic [IW-1:0]         w_sel;
   logic [3:0]            w_be;
   logic [2:0]            w_size;
   logic [1:0]            w_off;
   logic                  w_any_gnt;

   // First cycle of a two-cycle ERROR response: the next transfer must be cancelled.
   assign w_err_first = r_dp_vld & ahbl_hresp & ~ahbl_hready;

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      w_rr_idx = r_last_gnt;
      w_rr_hit = 1'b0;
      w_k      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_k = IW'((int'(r_last_gnt) + i) % NUM_REQ);
         if (!w_rr_hit && req_i[w_k]) begin
            w_rr_hit = 1'b1;
            w_rr_idx = w_k;
         end
      end
   end

   // A stalled NONSEQ keeps its owner so address/control stay stable until hready.
   assign w_sel    = r_lock_vld ? r_lock_idx : w_rr_idx;
   assign w_active = ((|req_i) | r_lock_vld) & ~w_err_first;

   // Byte enables determine transfer size and the low address bits.
   always_comb begin
      w_be   = be_i[w_sel];
      w_size = 3'b010;
      w_off  = 2'b00;
      case (w_be)
         4'b1111: begin w_size = 3'b010; w_off = 2'b00; end
         4'b0011: begin w_size = 3'b001; w_off = 2'b00; end
         4'b1100: begin w_size = 3'b001; w_off = 2'b10; end
         4'b0001: begin w_size = 3'b000; w_off = 2'b00; end
         4'b0010: begin w_size = 3'b000; w_off = 2'b01; end
         4'b0100: begin w_size = 3'b000; w_off = 2'b10; end
         4'b1000: begin w_size = 3'b000; w_off = 2'b11; end
         default: begin w_size = 3'b010; w_off = 2'b00; end
      endcase
   end

   // Address phase; idle bus drives the reset values.
   always_comb begin
      ahbl_htrans    = w_active ? HTRANS_NONSEQ : HTRANS_IDLE;
      ahbl_haddr     = w_active ? {addr_i[w_sel][ADDR_WIDTH-1:2], w_off} : '0;
      ahbl_hwrite    = w_active & we_i[w_sel];
      ahbl_hsize     = w_active ? w_size : 3'b010;
      ahbl_hprot     = !w_active ? 4'b0000 : ((w_sel == '0) ? 4'b0010 : 4'b0011);
      ahbl_hburst    = 3'b000;
      ahbl_hmastlock = 1'b0;
      ahbl_hwdata    = r_dp_wdata;
      gnt_o          = '0;
      if (req_i[w_sel] && ahbl_hready && !w_err_first) begin
         gnt_o[w_sel] = 1'b1;
      end
   end

   assign w_any_gnt = |gnt_o;

   // Data-phase response routed to the owner; write responses carry zero data.
   always_comb begin
      rvalid_o = '0;
      err_o    = '0;
      rdata_o  = '0;
      if (r_dp_vld && ahbl_hready) begin
         rvalid_o[r_dp_owner] = 1'b1;
         err_o[r_dp_owner]    = ahbl_hresp;
         if (!r_dp_we) begin
            rdata_o = ahbl_hrdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_last_gnt <= IW'(NUM_REQ - 1);
         r_lock_vld <= 1'b0;
         r_lock_idx <= '0;
         r_dp_vld   <= 1'b0;
         r_dp_owner <= '0;
         r_dp_we    <= 1'b0;
         r_dp_wdata <= '0;
      end else begin
         if (w_any_gnt) begin
            r_last_gnt <= w_sel;
         end

         if (w_err_first || ahbl_hready) begin
            r_lock_vld <= 1'b0;
         end else if (w_active) begin
            r_lock_vld <= 1'b1;
            r_lock_idx <= w_sel;
         end

         // Data phase advances only when the bus is ready; grants occur only then too.
         if (ahbl_hready) begin
            r_dp_vld <= w_any_gnt;
            if (w_any_gnt) begin
               r_dp_owner <= w_sel;
               r_dp_we    <= we_i[w_sel];
               r_dp_wdata <= wdata_i[w_sel];
            end
         end
      end
   end

endmodule

// File: tb/tb_ahblite_obi_arbiter.sv
// Directed stimulus with a response scoreboard for ahblite_obi_arbiter.
// Expected responses carry their owner, data, error and the cycle they must appear in.
// Address-phase outputs are checked in-line by the stimulus process.
module tb_ahblite_obi_arbiter;

   logic             clk = 1'b0;
   logic             rstn;
   logic [1:0]       req, we;
   logic [1:0][31:0] addr, wdata;
   logic [1:0][3:0]  be;
   logic             hready, hresp;
   logic [31:0]      hrdata;

   logic [1:0]       gnt, rvalid, err;
   logic [31:0]      rdata, haddr, hwdata;
   logic [2:0]       hburst, hsize;
   logic             hmastlock, hwrite;
   logic [3:0]       hprot;
   logic [1:0]       htrans;

   ahblite_obi_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REQ(2)) dut (
      .clk(clk), .rstn(rstn),
      .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
      .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
      .ahbl_haddr(haddr), .ahbl_hburst(hburst), .ahbl_hmastlock(hmastlock),
      .ahbl_hprot(hprot), .ahbl_hsize(hsize), .ahbl_htrans(htrans),
      .ahbl_hwdata(hwdata), .ahbl_hwrite(hwrite),
      .ahbl_hrdata(hrdata), .ahbl_hready(hready), .ahbl_hresp(hresp)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          owner;
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   cyc   = 0;
   int   n_chk = 0;
   int   n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int i, input logic r, input logic [31:0] a, input logic w,
                      input logic [3:0] b, input logic [31:0] d);
      req[i]   = r;
      addr[i]  = a;
      we[i]    = w;
      be[i]    = b;
      wdata[i] = d;
   endtask

   task automatic expect_rsp(input int o, input logic [31:0] d, input logic e, input int c);
      exp_t x;
      x.owner = o;
      x.data  = d;
      x.err   = e;
      x.cyc   = c;
      q.push_back(x);
   endtask

   // Response monitor: every rvalid must match the head of the scoreboard in the right cycle.
   always @(negedge clk) begin
      if (rstn) begin
         if (rvalid != 2'b00) begin
            if (q.size() == 0) begin
               chk("rsp_unexpected", {62'd0, rvalid}, 64'd0);
            end else begin
               mon_e = q.pop_front();
               chk("rsp_owner", {62'd0, rvalid}, 64'd1 << mon_e.owner);
               chk("rsp_rdata", {32'd0, rdata}, {32'd0, mon_e.data});
               chk("rsp_err",   {62'd0, err}, {63'd0, mon_e.err} << mon_e.owner);
               chk("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
         end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            chk("rsp_missing", 64'd0, 64'd1 << mon_e.owner);
         end
      end
   end

   logic [3:0] be_tab  [5] = '{4'b0011, 4'b1100, 4'b1000, 4'b0001, 4'b0110};
   logic [2:0] sz_tab  [5] = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd2};
   logic [1:0] off_tab [5] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd0};
   int         w0;

   initial begin
      rstn = 1'b0; req = '0; we = '0; addr = '0; be = '0; wdata = '0;
      hready = 1'b1; hresp = 1'b0; hrdata = '0;

      // Reset state
      @(negedge clk);
      chk("rst_gnt",    {62'd0, gnt}, 64'd0);
      chk("rst_rvalid", {62'd0, rvalid}, 64'd0);
      chk("rst_err",    {62'd0, err}, 64'd0);
      chk("rst_rdata",  {32'd0, rdata}, 64'd0);
      chk("rst_htrans", {62'd0, htrans}, 64'd0);
      chk("rst_haddr",  {32'd0, haddr}, 64'd0);
      chk("rst_hsize",  {61'd0, hsize}, 64'd2);
      chk("rst_hprot",  {60'd0, hprot}, 64'd0);
      chk("rst_hwdata", {32'd0, hwdata}, 64'd0);
      chk("rst_hwrite", {63'd0, hwrite}, 64'd0);
      next_cycle();
      rstn = 1'b1;
      next_cycle();

      // Byte write by requester 0
      drv(0, 1'b1, 32'h0000_0002, 1'b1, 4'b0100, 32'h00AB_0000);
      @(negedge clk);
      chk("bw_gnt",    {62'd0, gnt}, 64'b01);
      chk("bw_htrans", {62'd0, htrans}, 64'd2);
      chk("bw_haddr",  {32'd0, haddr}, 64'h2);
      chk("bw_hsize",  {61'd0, hsize}, 64'd0);
      chk("bw_hprot",  {60'd0, hprot}, 64'b0010);
      chk("bw_hwrite", {63'd0, hwrite}, 64'd1);
      expect_rsp(0, 32'h0, 1'b0, cyc + 1);
      next_cycle();
      drv(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      hrdata = 32'h1234_5678;
      @(negedge clk);
      chk("bw_hwdata", {32'd0, hwdata}, 64'h00AB_0000);
      chk("bw_idle",   {62'd0, htrans}, 64'd0);
      next_cycle();

      // Byte-enable to size/offset mapping, back-to-back reads by requester 0
      for (int k = 0; k < 5; k++) begin
         drv(0, 1'b1, 32'h0000_0040, 1'b0, be_tab[k], 32'h0);
         hrdata = 32'hB000_0000 + k;
         @(negedge clk);
         chk("be_gnt",   {62'd0, gnt}, 64'b01);
         chk("be_hsize", {61'd0, hsize}, {61'd0, sz_tab[k]});
         chk("be_haddr", {32'd0, haddr}, {32'd0, 32'h40 | {30'd0, off_tab[k]}});
         expect_rsp(0, 32'hB000_0000 + k + 1, 1'b0, cyc + 1);
         next_cycle();
      end
      drv(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      hrdata = 32'hB000_0005;
      @(negedge clk);
      next_cycle();

      // Single word read by requester 1
      drv(1, 1'b1, 32'h1000_0004, 1'b0, 4'hF, 32'h0);
      hrdata = 32'h0;
      @(negedge clk);
      chk("rd1_gnt",    {62'd0, gnt}, 64'b10);
      chk("rd1_htrans", {62'd0, htrans}, 64'd2);
      chk("rd1_hsize",  {61'd0, hsize}, 64'd2);
      chk("rd1_haddr",  {32'd0, haddr}, 64'h1000_0004);
      chk("rd1_hprot",  {60'd0, hprot}, 64'b0011);
      chk("rd1_hburst", {61'd0, hburst}, 64'd0);
      chk("rd1_hlock",  {63'd0, hmastlock}, 64'd0);
      expect_rsp(1, 32'hDEAD_BEEF, 1'b0, cyc + 1);
      next_cycle();
      drv(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      hrdata = 32'hDEAD_BEEF;
      @(negedge clk);
      next_cycle();

      // Continuous contention: grants alternate starting with 0
      drv(0, 1'b1, 32'h0000_1000, 1'b0, 4'hF, 32'h0);
      drv(1, 1'b1, 32'h0000_2000, 1'b0, 4'hF, 32'h0);
      for (int k = 0; k < 6; k++) begin
         hrdata = 32'hA000_0000 + k;
         @(negedge clk);
         chk("rr_gnt",   {62'd0, gnt}, (k % 2 == 0) ? 64'b01 : 64'b10);
         chk("rr_haddr", {32'd0, haddr}, (k % 2 == 0) ? 64'h1000 : 64'h2000);
         expect_rsp(k % 2, 32'hA000_0000 + k + 1, 1'b0, cyc + 1);
         next_cycle();
      end
      drv(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      drv(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      hrdata = 32'hA000_0006;
      @(negedge clk);
      next_cycle();

      // Two wait states with requester 0 pending; requester 1 arrives during the stall
      drv(0, 1'b1, 32'h0000_0300, 1'b0, 4'hF, 32'h0);
      hrdata = 32'h0;
      @(negedge clk);
      chk("ws_gnt0", {62'd0, gnt}, 64'b01);
      w0 = cyc;
      expect_rsp(0, 32'h5555_AAAA, 1'b0, w0 + 3);
      next_cycle();
      drv(0, 1'b1, 32'h0000_0400, 1'b0, 4'hF, 32'h0);
      hready = 1'b0;
      @(negedge clk);
      chk("ws1_gnt",    {62'd0, gnt}, 64'd0);
      chk("ws1_htrans", {62'd0, htrans}, 64'd2);
      chk("ws1_haddr",  {32'd0, haddr}, 64'h400);
      next_cycle();
      drv(1, 1'b1, 32'h0000_0500, 1'b0, 4'hF, 32'h0);
      @(negedge clk);
      chk("ws2_gnt",    {62'd0, gnt}, 64'd0);
      chk("ws2_htrans", {62'd0, htrans}, 64'd2);
      chk("ws2_haddr",  {32'd0, haddr}, 64'h400);
      next_cycle();
      hready = 1'b1;
      hrdata = 32'h5555_AAAA;
      @(negedge clk);
      chk("ws3_gnt",   {62'd0, gnt}, 64'b01);
      chk("ws3_haddr", {32'd0, haddr}, 64'h400);
      expect_rsp(0, 32'h0BAD_F00D, 1'b0, cyc + 1);
      next_cycle();
      drv(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      hrdata = 32'h0BAD_F00D;
      @(negedge clk);
      chk("ws4_gnt",   {62'd0, gnt}, 64'b10);
      chk("ws4_haddr", {32'd0, haddr}, 64'h500);
      expect_rsp(1, 32'h600D_CAFE, 1'b0, cyc + 1);
      next_cycle();
      drv(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      hrdata = 32'h600D_CAFE;
      @(negedge clk);
      next_cycle();

      // Two-cycle ERROR on requester 1 while requester 0 waits
      drv(1, 1'b1, 32'h0000_0700, 1'b0, 4'hF, 32'h0);
      hrdata = 32'h0;
      @(negedge clk);
      chk("er0_gnt", {62'd0, gnt}, 64'b10);
      expect_rsp(1, 32'h0, 1'b1, cyc + 2);
      next_cycle();
      drv(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      drv(0, 1'b1, 32'h0000_0800, 1'b0, 4'hF, 32'h0);
      hready = 1'b0;
      hresp  = 1'b1;
      @(negedge clk);
      chk("er1_htrans", {62'd0, htrans}, 64'd0);
      chk("er1_gnt",    {62'd0, gnt}, 64'd0);
      next_cycle();
      hready = 1'b1;
      @(negedge clk);
      chk("er2_gnt",    {62'd0, gnt}, 64'b01);
      chk("er2_htrans", {62'd0, htrans}, 64'd2);
      expect_rsp(0, 32'h1357_2468, 1'b0, cyc + 1);
      next_cycle();
      drv(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      hresp  = 1'b0;
      hrdata = 32'h1357_2468;
      @(negedge clk);
      next_cycle();

      // Reset during a pending data phase; response is dropped
      drv(0, 1'b1, 32'h0000_0900, 1'b1, 4'hF, 32'hCAFE_F00D);
      @(negedge clk);
      chk("rs0_gnt", {62'd0, gnt}, 64'b01);
      next_cycle();
      drv(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      hrdata = 32'h7777_7777;
      #1;
      chk("rs_pre_hwdata", {32'd0, hwdata}, 64'hCAFE_F00D);
      rstn = 1'b0;
      #1;
      chk("rs_rvalid", {62'd0, rvalid}, 64'd0);
      chk("rs_gnt",    {62'd0, gnt}, 64'd0);
      chk("rs_htrans", {62'd0, htrans}, 64'd0);
      chk("rs_hwdata", {32'd0, hwdata}, 64'd0);
      chk("rs_haddr",  {32'd0, haddr}, 64'd0);
      chk("rs_rdata",  {32'd0, rdata}, 64'd0);
      chk("rs_hsize",  {61'd0, hsize}, 64'd2);
      @(negedge clk);
      next_cycle();
      rstn = 1'b1;
      drv(0, 1'b1, 32'h0000_0A00, 1'b0, 4'hF, 32'h0);
      drv(1, 1'b1, 32'h0000_0B00, 1'b0, 4'hF, 32'h0);
      hrdata = 32'h0;
      @(negedge clk);
      chk("post_rst_gnt",   {62'd0, gnt}, 64'b01);
      chk("post_rst_haddr", {32'd0, haddr}, 64'hA00);
      expect_rsp(0, 32'h2468_ACE0, 1'b0, cyc + 1);
      next_cycle();
      drv(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      drv(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      hrdata = 32'h2468_ACE0;
      @(negedge clk);
      next_cycle();
      next_cycle();

      chk("rsp_outstanding", 64'(q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
